ysyx_23060208_ifu: RTL and testbench
====================================

Name: ysyx_23060208_ifu

Overview:
- Instruction fetch unit for the multicycle NPC core, directly downstream of the PC register.
- Latches the current pc and issues one read on a simplified AXI4-Lite read channel (AR/R).
- Captures the returned word and hands it to the IDU over a valid/ready handshake.
- Waits for the WBU retire pulse before fetching from the next (already updated) pc. Non-pipelined: at most one instruction in flight.

Parameters:
- DATA_WIDTH, 32, width of the pc, address and instruction words.
- CNT_WIDTH, 32, width of the completed-fetch performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc  in  DATA_WIDTH  current pc from the PC register.
- wb_done  in  1  single-cycle pulse from the WBU: the instruction has retired and the PC register writes next_pc on this same edge.
- arvalid  out  1  read address valid.
- araddr  out  DATA_WIDTH  read address.
- arready  in  1  read address ready.
- rvalid  in  1  read data valid.
- rdata  in  DATA_WIDTH  read data.
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error.
- rready  out  1  read data ready.
- inst_valid  out  1  instruction valid to the IDU.
- inst_ready  in  1  IDU ready.
- inst  out  DATA_WIDTH  fetched instruction.
- inst_pc  out  DATA_WIDTH  pc of inst.
- fetch_err  out  1  access fault for inst: misaligned pc or rresp != OKAY. Valid with inst_valid.
- fetch_cnt  out  CNT_WIDTH  number of instructions accepted by the IDU.

Behaviour:

States:
- START: pc_q <= pc.
  - If pc[1:0] != 0: err_q <= 1, inst_q <= 0, go to OUT. No bus access.
  - Else: err_q <= 0, go to AR.
- AR: arvalid = 1, araddr = pc_q (stable while waiting).
  - On arvalid && arready: go to R.
  - arvalid is never withdrawn before the handshake.
- R: rready = 1.
  - On rvalid: inst_q <= rdata, err_q <= (rresp != 2'b00), go to OUT.
  - rdata is captured even on error.
- OUT: inst_valid = 1; inst, inst_pc and fetch_err are driven from inst_q, pc_q and err_q and held stable while waiting.
  - On inst_ready: fetch_cnt += 1 (wraps modulo 2^CNT_WIDTH), go to WB.
- WB: all handshake outputs low.
  - On wb_done: go to START. START samples the pc written on the wb_done edge.

Output rules:
- All outputs are Moore, decoded from the registered state; there are no combinational paths from inputs to outputs.
- Outputs are 0 in every state other than the one that drives them.
- Reset values: state = START, arvalid = 0, rready = 0, inst_valid = 0, inst = 0, inst_pc = 0, fetch_err = 0, fetch_cnt = 0.
- araddr = 0 when arvalid = 0.

Latency (arready and rvalid already high, inst_ready high):
- wb_done at cycle t.
- START at t+1.
- AR handshake at t+2.
- R handshake at t+3.
- inst_valid at t+4; IDU acceptance at t+4.
- First fetch after reset: START is the first cycle with rst low; arvalid rises in the cycle after.

Boundary conditions:
- wb_done outside WB: ignored, no state change. Simulation assertion fires.
- rvalid in START, AR, OUT or WB: ignored, nothing captured.
- arready without arvalid: no effect.
- Back-pressure: inst_ready low holds OUT indefinitely with stable outputs. Stall in AR/R waiting for arready/rvalid is unbounded.
- pc changing while in AR..OUT does not affect araddr or inst_pc.
- rst asserted in any state: next cycle is START with reset values. Any outstanding bus transaction is abandoned; memory shares the same rst.
- fetch_cnt at all ones + 1 wraps to 0.

Test Plan:
- Reset release, pc = 0x80000000, memory returns 0x00100093 with arready = 1 and rvalid on the cycle after the AR handshake -> araddr = 0x80000000 with arvalid high in cycle 2 after rst low; inst_valid high in cycle 4 with inst = 0x00100093, inst_pc = 0x80000000, fetch_err = 0; fetch_cnt = 1 after acceptance.
- Back-pressure: arready delayed 3 cycles, rvalid delayed 5, inst_ready low for 4 cycles -> arvalid/araddr and inst/inst_pc stay stable throughout; exactly one AR and one R handshake; fetch_cnt increments once.
- Sequential fetch: wb_done pulsed with pc updated to 0x80000004 -> next araddr = 0x80000004 exactly 2 cycles after wb_done; a wb_done pulse injected while in R is ignored (no extra fetch).
- Errors: pc = 0x80000002 -> no arvalid, inst_valid with fetch_err = 1, inst = 0. rresp = 2'b10 with rdata = 0xDEADBEEF -> fetch_err = 1, inst = 0xDEADBEEF.
- Reset mid-operation: rst asserted while in R -> next cycle all outputs at reset values; fetch restarts from START and the late rvalid is ignored.
- Counter wrap: CNT_WIDTH = 4, 17 accepted fetches -> fetch_cnt = 1.

Source files
------------

// File: rtl/ysyx_23060208_ifu.sv
// ============================================================================
// ysyx_23060208_ifu -- instruction fetch unit of the multicycle NPC core.
//
// Latches the current pc, issues one read on a simplified AXI4-Lite read
// channel (AR/R), captures the returned word and offers it to the IDU.
// It then waits for the WBU retire pulse before fetching from the updated pc.
// At most one instruction is in flight.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   pc              current pc from the PC register
//   wb_done         retire pulse from the WBU (PC register updates same edge)
//   arvalid/araddr/arready          read address channel
//   rvalid/rdata/rresp/rready       read data channel (rresp 2'b00 = OKAY)
//   inst_valid/inst_ready           instruction handshake to the IDU
//   inst, inst_pc, fetch_err        fetched word, its pc, access fault flag
//   fetch_cnt       number of instructions accepted by the IDU (wraps)
//   o_dbg_state     current FSM state, for debug and checkers
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid, once raised, is held with stable payload until that
// transfer. Every output is decoded from the registered state only, so no
// input reaches an output combinationally.
// ============================================================================
module ysyx_23060208_ifu #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  wb_done,
    output logic                  arvalid,
    output logic [DATA_WIDTH-1:0] araddr,
    input  logic                  arready,
    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    output logic                  rready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fetch_err,
    output logic [CNT_WIDTH-1:0]  fetch_cnt,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_OUT   = 3'd3,
        S_WB    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_misaligned;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    assign w_misaligned = (pc[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        w_next_state = r_state;
        arvalid      = 1'b0;
        araddr       = '0;
        rready       = 1'b0;
        inst_valid   = 1'b0;
        inst         = '0;
        inst_pc      = '0;
        fetch_err    = 1'b0;
        case (r_state)
            S_START: begin
                // A misaligned pc never touches the bus; the fault is
                // reported straight to the IDU.
                w_next_state = w_misaligned ? S_OUT : S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                araddr  = r_pc;
                if (arready) w_next_state = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) w_next_state = S_OUT;
            end
            S_OUT: begin
                inst_valid = 1'b1;
                inst       = r_inst;
                inst_pc    = r_pc;
                fetch_err  = r_err;
                if (inst_ready) w_next_state = S_WB;
            end
            S_WB: begin
                if (wb_done) w_next_state = S_START;
            end
            default: w_next_state = S_START;
        endcase
    end

    // Datapath: fetch pc, instruction word, fault flag and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_inst <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_START: begin
                    r_pc <= pc;
                    if (w_misaligned) begin
                        r_err  <= 1'b1;
                        r_inst <= '0;
                    end else begin
                        r_err <= 1'b0;
                    end
                end
                S_R: begin
                    // Data is kept even on an error response.
                    if (rvalid) begin
                        r_inst <= rdata;
                        r_err  <= (rresp != 2'b00);
                    end
                end
                S_OUT: begin
                    if (inst_ready) r_cnt <= r_cnt + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign fetch_cnt   = r_cnt;
    assign o_dbg_state = r_state;

`ifndef SYNTHESIS
    // A retire pulse outside WB points at a WBU/IFU sequencing bug upstream;
    // it is ignored by the FSM but flagged here.
    always_ff @(posedge clk) begin
        if (!rst && wb_done) begin
            assert (r_state == S_WB)
            else $warning("ifu: wb_done seen outside WB state, ignored");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// Directed bench for ysyx_23060208_ifu. The counter is instantiated 4 bits
// wide so that the wrap is reachable in a short run.
module tb_ysyx_23060208_ifu;
    localparam int DW = 32;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pc;
    logic          wb_done;
    logic          arvalid;
    logic [DW-1:0] araddr;
    logic          arready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rready;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [DW-1:0] inst_pc;
    logic          fetch_err;
    logic [CW-1:0] fetch_cnt;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    ysyx_23060208_ifu #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .pc(pc), .wb_done(wb_done),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err),
        .fetch_cnt(fetch_cnt), .o_dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    // Handshake monitors, sampled away from the active edge.
    int ar_hs = 0;
    int r_hs  = 0;
    always @(negedge clk) begin
        if (arvalid && arready) ar_hs++;
        if (rvalid && rready) r_hs++;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From WB: pulse wb_done for one cycle, present new_pc after that edge.
    // Returns in the START cycle (t+1).
    task automatic retire(input logic [DW-1:0] new_pc);
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        pc      = new_pc;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; pc = 32'h8000_0000; wb_done = 0; arready = 0;
        rvalid = 0; rdata = '0; rresp = 2'b00; inst_ready = 0;
        tick(); tick();
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %0h exp 0", arvalid); end
        checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", araddr); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %0h exp 0", rready); end
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || fetch_err !== 1'b0)
            begin errors++; $display("FAIL reset_inst got v=%0h i=%h pc=%h e=%0h exp all 0", inst_valid, inst, inst_pc, fetch_err); end
        checks++; if (fetch_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fetch_cnt); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_first_fetch();
        arready = 1'b1; inst_ready = 1'b1;
        rst = 1'b0;                       // cycle 1: START
        tick();                           // cycle 2: AR
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000)
            begin errors++; $display("FAIL first_ar got v=%0h a=%h exp 1 80000000", arvalid, araddr); end
        tick();                           // cycle 3: R
        checks++; if (rready !== 1'b1 || arvalid !== 1'b0)
            begin errors++; $display("FAIL first_r got rready=%0h arvalid=%0h exp 1 0", rready, arvalid); end
        rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'b00;
        tick();                           // cycle 4: OUT
        rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0000 || fetch_err !== 1'b0)
            begin errors++; $display("FAIL first_out got v=%0h i=%h pc=%h e=%0h exp 1 00100093 80000000 0", inst_valid, inst, inst_pc, fetch_err); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL first_cnt_pre got %0d exp %0d", fetch_cnt, exp_cnt); end
        tick();                           // cycle 5: WB
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL first_cnt got %0d exp %0d", fetch_cnt, exp_cnt); end
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || dbg_state !== 3'd4)
            begin errors++; $display("FAIL first_wb got v=%0h i=%h st=%0d exp 0 0 4", inst_valid, inst, dbg_state); end
    endtask

    task automatic test_seq_fetch();
        int ar0;
        ar0 = ar_hs;
        retire(32'h8000_0004);            // t+1: START
        checks++; if (arvalid !== 1'b0 || dbg_state !== 3'd0)
            begin errors++; $display("FAIL seq_start got arvalid=%0h st=%0d exp 0 0", arvalid, dbg_state); end
        tick();                           // t+2: AR
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004)
            begin errors++; $display("FAIL seq_ar got v=%0h a=%h exp 1 80000004", arvalid, araddr); end
        tick();                           // R: stray retire pulse
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        checks++; if (rready !== 1'b1 || dbg_state !== 3'd2)
            begin errors++; $display("FAIL seq_stray_wb got rready=%0h st=%0d exp 1 2", rready, dbg_state); end
        rvalid = 1'b1; rdata = 32'h0020_0113;
        tick();                           // OUT
        rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || inst_pc !== 32'h8000_0004)
            begin errors++; $display("FAIL seq_out got v=%0h i=%h pc=%h exp 1 00200113 80000004", inst_valid, inst, inst_pc); end
        tick();                           // WB
        exp_cnt = exp_cnt + 1'b1;
        tick(); tick();                   // must stay in WB: no extra fetch
        checks++; if (dbg_state !== 3'd4 || arvalid !== 1'b0 || ar_hs - ar0 != 1)
            begin errors++; $display("FAIL seq_no_extra got st=%0d arvalid=%0h ar_hs=%0d exp 4 0 1", dbg_state, arvalid, ar_hs - ar0); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL seq_cnt got %0d exp %0d", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_back_pressure();
        int ar0, r0;
        logic stable;
        ar0 = ar_hs; r0 = r_hs;
        arready = 1'b0; inst_ready = 1'b0;
        retire(32'h8000_0008);            // START
        tick();                           // AR, arready low 3 cycles
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (arvalid !== 1'b1 || araddr !== 32'h8000_0008) stable = 1'b0;
            pc = $urandom_range(0, 255) * 4;
            tick();
        end
        checks++; if (stable !== 1'b1 || arvalid !== 1'b1 || araddr !== 32'h8000_0008)
            begin errors++; $display("FAIL bp_ar_stable got v=%0h a=%h exp 1 80000008", arvalid, araddr); end
        arready = 1'b1;
        tick();                           // R, rvalid low 5 cycles
        arready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rready !== 1'b1 || arvalid !== 1'b0) stable = 1'b0;
            tick();
        end
        checks++; if (stable !== 1'b1 || rready !== 1'b1)
            begin errors++; $display("FAIL bp_r_wait got rready=%0h exp 1", rready); end
        rvalid = 1'b1; rdata = 32'h0030_8193; rresp = 2'b00;
        tick();                           // OUT, inst_ready low 4 cycles
        rvalid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inst_valid !== 1'b1 || inst !== 32'h0030_8193 || inst_pc !== 32'h8000_0008 || fetch_err !== 1'b0)
                stable = 1'b0;
            pc = $urandom_range(0, 255) * 4;
            tick();
        end
        checks++; if (stable !== 1'b1 || inst !== 32'h0030_8193 || inst_pc !== 32'h8000_0008)
            begin errors++; $display("FAIL bp_out_stable got i=%h pc=%h exp 00308193 80000008", inst, inst_pc); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt_held got %0d exp %0d", fetch_cnt, exp_cnt); end
        inst_ready = 1'b1;
        tick();                           // WB
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (ar_hs - ar0 != 1 || r_hs - r0 != 1)
            begin errors++; $display("FAIL bp_handshakes got ar=%0d r=%0d exp 1 1", ar_hs - ar0, r_hs - r0); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt got %0d exp %0d", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_misaligned();
        int ar0;
        ar0 = ar_hs;
        arready = 1'b1;
        retire(32'h8000_0002);            // START
        tick();                           // OUT directly
        checks++; if (arvalid !== 1'b0 || inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h8000_0002)
            begin errors++; $display("FAIL misaligned got ar=%0h v=%0h e=%0h i=%h pc=%h exp 0 1 1 0 80000002", arvalid, inst_valid, fetch_err, inst, inst_pc); end
        tick();                           // WB
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (ar_hs != ar0 || fetch_cnt !== exp_cnt)
            begin errors++; $display("FAIL misaligned_nobus got ar=%0d cnt=%0d exp 0 %0d", ar_hs - ar0, fetch_cnt, exp_cnt); end
    endtask

    task automatic test_rresp_err();
        retire(32'h8000_000C);            // START
        tick();                           // AR
        tick();                           // R
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        tick();                           // OUT
        rvalid = 1'b0; rresp = 2'b00;
        checks++; if (inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== 32'hDEAD_BEEF || inst_pc !== 32'h8000_000C)
            begin errors++; $display("FAIL rresp_err got v=%0h e=%0h i=%h pc=%h exp 1 1 deadbeef 8000000c", inst_valid, fetch_err, inst, inst_pc); end
        tick();                           // WB
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL rresp_cnt got %0d exp %0d", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        retire(32'h8000_0010);            // START
        tick();                           // AR
        tick();                           // R
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rmid_in_r got rready=%0h exp 1", rready); end
        rst = 1'b1;
        tick();                           // reset applied
        exp_cnt = '0;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || fetch_err !== 1'b0 || fetch_cnt !== 4'd0 || dbg_state !== 3'd0)
            begin errors++; $display("FAIL rmid_outputs got ar=%0h rr=%0h v=%0h cnt=%0d st=%0d exp all 0", arvalid, rready, inst_valid, fetch_cnt, dbg_state); end
        rst = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0; arready = 1'b0;   // START, late rvalid
        tick();                           // AR
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010 || rready !== 1'b0)
            begin errors++; $display("FAIL rmid_restart got v=%0h a=%h rr=%0h exp 1 80000010 0", arvalid, araddr, rready); end
        tick();                           // still AR: rvalid ignored
        checks++; if (dbg_state !== 3'd1) begin errors++; $display("FAIL rmid_ignore_r got st=%0d exp 1", dbg_state); end
        rvalid = 1'b0; arready = 1'b1;
        tick();                           // R
        rvalid = 1'b1; rdata = 32'h0040_0213;
        tick();                           // OUT
        rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0040_0213)
            begin errors++; $display("FAIL rmid_inst got v=%0h i=%h exp 1 00400213", inst_valid, inst); end
        tick();                           // WB
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL rmid_cnt got %0d exp %0d", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_cnt_wrap();
        rst = 1'b1; wb_done = 1'b0; pc = 32'h8000_0000;
        tick();
        exp_cnt = '0;
        rst = 1'b0; arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0013;
        rresp = 2'b00; inst_ready = 1'b1;  // START
        for (int k = 0; k < 17; k++) begin
            tick();                       // AR
            tick();                       // R
            tick();                       // OUT
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL wrap_out_%0d got %0h exp 1", k, inst_valid); end
            tick();                       // WB
            exp_cnt = exp_cnt + 1'b1;
            checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt_%0d got %0d exp %0d", k, fetch_cnt, exp_cnt); end
            retire(pc + 32'd4);           // START
        end
        rvalid = 1'b0;
        checks++; if (fetch_cnt !== 4'd1) begin errors++; $display("FAIL wrap_final got %0d exp 1", fetch_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_fetch();
        test_seq_fetch();
        test_back_pressure();
        test_misaligned();
        test_rresp_err();
        test_reset_mid();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
